// File: rtl/udp_jk_ff_pkg.sv
// Shared definitions for the JK flip-flop bank.
package udp_jk_ff_pkg;

    // Encoding of the per-bit {j,k} control pair.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

endpackage

// File: rtl/udp_jk_ff_jk_bit.sv
// Single JK storage bit with synchronous active-low clear.
module udp_jk_ff_jk_bit
    import udp_jk_ff_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next state from the JK pair; unknown controls give an unknown bit.
    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = 1'bx;
        endcase
    end

    // State register; clear wins over every JK combination.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/udp_jk_ff.sv
// Bank of independent JK flip-flops with synchronous active-low clear.
module udp_jk_ff
    import udp_jk_ff_pkg::*;
#(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    // One JK bit per lane; lanes never interact.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        udp_jk_ff_jk_bit u_bit (
            .clk     (clk),
            .clr_n   (clr_n),
            .j       (j[i]),
            .k       (k[i]),
            .rst_val (RESET_VAL[i]),
            .q       (q[i])
        );
    end

    // Complement output taken straight from the flops.
    assign q_n = ~q;

endmodule

// File: tb/tb_udp_jk_ff.sv
// Self-checking bench for udp_jk_ff: 1-bit default and 4-bit variant.
module tb_udp_jk_ff;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [0:0] j1, k1, q1, qn1;
    logic [3:0] j4, k4, q4, qn4;

    int unsigned n_checks   = 0;
    int unsigned n_failures = 0;

    logic [0:0] m1;
    logic [3:0] m4;
    logic [0:0] exp1_q[$];
    logic [3:0] exp4_q[$];

    always #5 clk = ~clk;

    udp_jk_ff #(.WIDTH(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .j(j1), .k(k1), .q(q1), .q_n(qn1)
    );

    udp_jk_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
        .clk(clk), .clr_n(clr_n), .j(j4), .k(k4), .q(q4), .q_n(qn4)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference JK behaviour, bit by bit.
    function automatic logic [3:0] jk_model(input logic [3:0] cur, input logic c,
                                            input logic [3:0] jv, input logic [3:0] kv,
                                            input logic [3:0] rv);
        logic [3:0] nx;
        if (!c) return rv;
        for (int i = 0; i < 4; i++) begin
            if (!jv[i] && !kv[i])     nx[i] = cur[i];
            else if (!jv[i] && kv[i]) nx[i] = 1'b0;
            else if (jv[i] && !kv[i]) nx[i] = 1'b1;
            else                      nx[i] = ~cur[i];
        end
        return nx;
    endfunction

    // Update both models for the coming edge and queue the expectations.
    task automatic push_expect();
        logic [3:0] t;
        t  = jk_model({3'b000, m1}, clr_n, {3'b000, j1}, {3'b000, k1}, 4'b0000);
        m1 = t[0:0];
        m4 = jk_model(m4, clr_n, j4, k4, 4'b1010);
        exp1_q.push_back(m1);
        exp4_q.push_back(m4);
    endtask

    task automatic pop_check(input string tag);
        logic [0:0] e1;
        logic [3:0] e4;
        if (exp1_q.size() == 0 || exp4_q.size() == 0) begin
            check({tag, "_sb_empty"}, 4'd1, 4'd0);
            return;
        end
        e1 = exp1_q.pop_front();
        e4 = exp4_q.pop_front();
        check({tag, "_q1"},  {3'b000, q1},  {3'b000, e1});
        check({tag, "_qn1"}, {3'b000, qn1}, {3'b000, ~e1});
        check({tag, "_q4"},  q4,  e4);
        check({tag, "_qn4"}, qn4, ~e4);
    endtask

    // One full cycle: verify the falling edge left q alone, drive, then check after the rising edge.
    task automatic step(input logic c, input logic jv, input logic kv,
                        input logic [3:0] jw, input logic [3:0] kw, input string tag);
        @(negedge clk);
        #1;
        check({tag, "_fall"}, {3'b000, q1}, {3'b000, m1});
        clr_n = c; j1 = jv; k1 = kv; j4 = jw; k4 = kw;
        push_expect();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m1 = 'x; m4 = 'x;
        clr_n = 1'b1; j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;

        // Clear asserted 3..13 ns across the 5 ns edge.
        #3 clr_n = 1'b0;
        push_expect();
        @(posedge clk); #1;
        pop_check("clr");
        check("clr_const", q4, 4'b1010);
        #7 clr_n = 1'b1;
        push_expect();
        @(posedge clk); #1;
        pop_check("clr_release_hold");

        // Hold, set, reset.
        step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, "hold0");
        step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, "hold1");
        step(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, "set");
        check("set_const", {3'b000, q1}, 4'd1);
        step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, "reset");
        check("reset_const", {3'b000, q1}, 4'd0);

        // Toggle for four edges: 1,0,1,0.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, $sformatf("toggle%0d", i));
            check($sformatf("toggle%0d_const", i), {3'b000, q1}, (i % 2 == 0) ? 4'd1 : 4'd0);
        end

        // Clear pulse with no rising edge inside it is ignored.
        step(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, "preset");
        #2 clr_n = 1'b0;
        #3 clr_n = 1'b1;
        #1;
        check("pulse_q1", {3'b000, q1}, 4'd1);

        // Clear across an edge mid-toggle, held while j=k=1.
        step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, "tog_pre");
        step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, "tog_pre2");
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, "clr_tog0");
        check("clr_tog0_const", {3'b000, q1}, 4'd0);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, "clr_tog1");
        step(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, "tog_restart");
        check("tog_restart_const", {3'b000, q1}, 4'd1);

        // Clear has priority over set; release 2 ns before an edge.
        step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, "prio");
        check("prio_const", {3'b000, q1}, 4'd0);
        @(negedge clk); #3;
        clr_n = 1'b1;
        push_expect();
        @(posedge clk); #1;
        pop_check("release");
        check("release_const", {3'b000, q1}, 4'd1);

        // 4-bit: clear to 1010, then toggle/set/reset/hold across lanes.
        step(1'b0, 1'b0, 1'b0, 4'b0011, 4'b0101, "w4_clr");
        check("w4_clr_const", q4, 4'b1010);
        step(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0101, "w4_mix");
        check("w4_mix_const", q4, 4'b1011);
        check("w4_mix_qn_const", qn4, 4'b0100);

        check("sb_drained", 4'(exp1_q.size() + exp4_q.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
